// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL / SRL / SRA / ROR) for the execute stage.
// The log2(XLEN) shift levels are spread over PIPE_STAGES register stages.
// A valid/ready handshake with bubble collapse lets it run beside the ALU
// as a multi-cycle unit, and a sideband tag travels with each operation.
module pipelined_shifter #(
    parameter int XLEN        = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [$clog2(XLEN)-1:0]  operand_b_i,
    input  logic [1:0]               op_i,
    input  logic [TAG_W-1:0]         tag_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [XLEN-1:0]          shift_data_o,
    output logic [TAG_W-1:0]         tag_o
);

    localparam int LEVELS = $clog2(XLEN);
    // Levels handled per stage; the last stage may get fewer (or none)
    localparam int LPS    = (LEVELS + PIPE_STAGES - 1) / PIPE_STAGES;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    // Stage registers: everything a later level needs rides along with the data
    logic [PIPE_STAGES-1:0] valid_reg;
    logic [PIPE_STAGES-1:0] fill_reg;
    logic [XLEN-1:0]        data_reg [PIPE_STAGES];
    logic [LEVELS-1:0]      amt_reg  [PIPE_STAGES];
    logic [1:0]             op_reg   [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_reg  [PIPE_STAGES];

    // Inputs seen by each stage's combinational levels
    logic [PIPE_STAGES-1:0] stg_valid;
    logic [PIPE_STAGES-1:0] stg_fill;
    logic [XLEN-1:0]        stg_data [PIPE_STAGES];
    logic [LEVELS-1:0]      stg_amt  [PIPE_STAGES];
    logic [1:0]             stg_op   [PIPE_STAGES];
    logic [TAG_W-1:0]       stg_tag  [PIPE_STAGES];
    logic [XLEN-1:0]        data_next [PIPE_STAGES];

    logic [PIPE_STAGES-1:0] stage_ready;
    logic                   ready_chain;
    logic                   unused_sink;

    // One shift level by a constant distance sh (always < XLEN)
    function automatic logic [XLEN-1:0] shift_by(
        input logic [XLEN-1:0] d,
        input logic [1:0]      op,
        input logic            fill,
        input int              sh
    );
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] fill_mask;
        fill_mask = ~({XLEN{1'b1}} >> sh);
        res       = d;
        case (op)
            OP_SLL: res = d << sh;
            OP_SRL: res = d >> sh;
            OP_SRA: res = (d >> sh) | (fill ? fill_mask : '0);
            OP_ROR: res = (d >> sh) | (d << (XLEN - sh));
        endcase
        return res;
    endfunction

    generate
        for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
            localparam int LO     = gi * LPS;
            localparam int HI_RAW = (gi + 1) * LPS;
            localparam int HI     = (HI_RAW < LEVELS) ? HI_RAW : LEVELS;
            localparam int NLEV   = (HI > LO) ? (HI - LO) : 0;

            // Stage 0 is fed from the ports, later stages from the previous register
            if (gi == 0) begin : g_src_port
                assign stg_valid[gi] = in_valid_i;
                assign stg_data[gi]  = operand_a_i;
                assign stg_amt[gi]   = operand_b_i;
                assign stg_op[gi]    = op_i;
                assign stg_tag[gi]   = tag_i;
                // SRA fill bit is captured once from the original operand
                assign stg_fill[gi]  = (op_i == OP_SRA) && operand_a_i[XLEN-1];
            end else begin : g_src_reg
                assign stg_valid[gi] = valid_reg[gi-1];
                assign stg_data[gi]  = data_reg[gi-1];
                assign stg_amt[gi]   = amt_reg[gi-1];
                assign stg_op[gi]    = op_reg[gi-1];
                assign stg_tag[gi]   = tag_reg[gi-1];
                assign stg_fill[gi]  = fill_reg[gi-1];
            end

            // Chain of levels owned by this stage, ascending shift distance
            logic [XLEN-1:0] lvl [NLEV+1];
            assign lvl[0] = stg_data[gi];
            for (genvar li = 0; li < NLEV; li++) begin : g_level
                localparam int K = LO + li;
                assign lvl[li+1] = stg_amt[gi][K]
                                 ? shift_by(lvl[li], stg_op[gi], stg_fill[gi], 1 << K)
                                 : lvl[li];
            end
            assign data_next[gi] = lvl[NLEV];
        end
    endgenerate

    // Backpressure chain: a stage can load if it is empty or its successor can load
    always_comb begin
        ready_chain = out_ready_i;
        stage_ready = '0;
        for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
            stage_ready[s] = !valid_reg[s] || ready_chain;
            ready_chain    = stage_ready[s];
        end
    end

    // Stage registers: reset clears everything, flush only kills valid bits
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_reg <= '0;
            fill_reg  <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                data_reg[s] <= '0;
                amt_reg[s]  <= '0;
                op_reg[s]   <= '0;
                tag_reg[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                if (flush_i) begin
                    valid_reg[s] <= 1'b0;
                end else if (stage_ready[s]) begin
                    valid_reg[s] <= stg_valid[s];
                    fill_reg[s]  <= stg_fill[s];
                    data_reg[s]  <= data_next[s];
                    amt_reg[s]   <= stg_amt[s];
                    op_reg[s]    <= stg_op[s];
                    tag_reg[s]   <= stg_tag[s];
                end
            end
        end
    end

    assign in_ready_o   = stage_ready[0];
    assign out_valid_o  = valid_reg[PIPE_STAGES-1];
    assign shift_data_o = data_reg[PIPE_STAGES-1];
    assign tag_o        = tag_reg[PIPE_STAGES-1];

    // Sideband carried into the final stage has no consumer past it
    assign unused_sink = ^{op_reg[PIPE_STAGES-1], fill_reg[PIPE_STAGES-1],
                           amt_reg[PIPE_STAGES-1]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: three instances (PIPE_STAGES = 1, 2, 3) share
// operand/op/tag/out_ready; each has its own in_valid enable so streams can
// be aimed at one instance. A negedge monitor keeps a per-instance scoreboard.
module tb_pipelined_shifter;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int ND    = 3;

    logic              clk = 1'b0;
    logic              rst_n, flush, drv_valid, out_ready;
    logic [2:0]        en;
    logic [XLEN-1:0]   drv_a, drv_exp;
    logic [4:0]        drv_b;
    logic [1:0]        drv_op;
    logic [TAG_W-1:0]  drv_tag;
    logic [2:0]        dut_valid, ir, ov;
    logic [2:0][XLEN-1:0]  od;
    logic [2:0][TAG_W-1:0] ot;

    int vectors = 0;
    int miscompares = 0;

    logic [XLEN+TAG_W-1:0] sb [ND][64];
    int  wr [ND];
    int  rd [ND];
    int  pops [ND];
    bit  hold_prev [ND];
    logic [XLEN-1:0]  prev_d [ND];
    logic [TAG_W-1:0] prev_t [ND];
    bit  done;

    always #5 clk = ~clk;

    assign dut_valid = {3{drv_valid}} & en;

    pipelined_shifter #(.XLEN(XLEN), .PIPE_STAGES(1), .TAG_W(TAG_W)) u_p1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(dut_valid[0]),
        .in_ready_o(ir[0]), .operand_a_i(drv_a), .operand_b_i(drv_b), .op_i(drv_op),
        .tag_i(drv_tag), .out_valid_o(ov[0]), .out_ready_i(out_ready),
        .shift_data_o(od[0]), .tag_o(ot[0]));
    pipelined_shifter #(.XLEN(XLEN), .PIPE_STAGES(2), .TAG_W(TAG_W)) u_p2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(dut_valid[1]),
        .in_ready_o(ir[1]), .operand_a_i(drv_a), .operand_b_i(drv_b), .op_i(drv_op),
        .tag_i(drv_tag), .out_valid_o(ov[1]), .out_ready_i(out_ready),
        .shift_data_o(od[1]), .tag_o(ot[1]));
    pipelined_shifter #(.XLEN(XLEN), .PIPE_STAGES(3), .TAG_W(TAG_W)) u_p3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(dut_valid[2]),
        .in_ready_o(ir[2]), .operand_a_i(drv_a), .operand_b_i(drv_b), .op_i(drv_op),
        .tag_i(drv_tag), .out_valid_o(ov[2]), .out_ready_i(out_ready),
        .shift_data_o(od[2]), .tag_o(ot[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] b,
                                              input logic [1:0] op);
        logic [31:0] r;
        case (op)
            2'b00:   r = a << b;
            2'b01:   r = a >> b;
            2'b11:   r = 32'($signed(a) >>> b);
            default: r = (b == 5'd0) ? a : ((a >> b) | (a << (32 - int'(b))));
        endcase
        return r;
    endfunction

    // Scoreboard monitor, sampled on the falling edge
    initial begin
        for (int d = 0; d < ND; d++) begin
            wr[d] = 0; rd[d] = 0; pops[d] = 0; hold_prev[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                if (!rst_n || flush) begin
                    rd[d] = wr[d];
                    hold_prev[d] = 1'b0;
                end else begin
                    if (hold_prev[d]) begin
                        chk($sformatf("p%0d_hold_valid", d + 1), 64'(ov[d]), 64'(1));
                        chk($sformatf("p%0d_hold_data", d + 1), 64'({od[d], ot[d]}),
                            64'({prev_d[d], prev_t[d]}));
                    end
                    if (ov[d] && out_ready) begin
                        if (rd[d] == wr[d]) begin
                            chk($sformatf("p%0d_spurious_out", d + 1), 64'(1), 64'(0));
                        end else begin
                            chk($sformatf("p%0d_result", d + 1), 64'({od[d], ot[d]}),
                                64'(sb[d][rd[d] % 64]));
                            rd[d]++;
                            pops[d]++;
                        end
                    end
                    if (dut_valid[d] && ir[d]) begin
                        sb[d][wr[d] % 64] = {drv_exp, drv_tag};
                        wr[d]++;
                    end
                    hold_prev[d] = ov[d] && !out_ready;
                    prev_d[d] = od[d];
                    prev_t[d] = ot[d];
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one op to instance d and hold it until accepted
    task automatic send(input int d, input logic [31:0] a, input logic [4:0] b,
                        input logic [1:0] op, input logic [4:0] tag, input logic [31:0] exp);
        en = 3'b001 << d;
        drv_a = a; drv_b = b; drv_op = op; drv_tag = tag; drv_exp = exp;
        drv_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (ir[d]) begin
                @(posedge clk); #1;
                drv_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk($sformatf("p%0d_send_timeout", d + 1), 64'(0), 64'(1));
        drv_valid = 1'b0;
    endtask

    // Issue to all idle instances; valid must pulse exactly PIPE_STAGES cycles later
    task automatic lat_check(input logic [31:0] a, input logic [4:0] b, input logic [1:0] op,
                             input logic [4:0] tag, input logic [31:0] exp);
        en = 3'b111;
        drv_a = a; drv_b = b; drv_op = op; drv_tag = tag; drv_exp = exp;
        drv_valid = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            drv_valid = 1'b0;
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("lat_valid_p%0d_c%0d", d + 1, c), 64'(ov[d]), 64'(c == d + 1));
                if (c == d + 1)
                    chk($sformatf("lat_data_p%0d_tag%0d", d + 1, tag),
                        64'({od[d], ot[d]}), 64'({exp, tag}));
            end
        end
    endtask

    task automatic wait_drain(input int d);
        for (int t = 0; t < 50 && rd[d] != wr[d]; t++) begin
            @(posedge clk); #1;
        end
        chk($sformatf("p%0d_drain", d + 1), 64'(wr[d] - rd[d]), 64'(0));
    endtask

    initial begin
        int p0;
        logic [31:0] ra;
        logic [4:0]  rb;
        logic [1:0]  rop;
        rst_n = 1'b0; flush = 1'b0; drv_valid = 1'b0; out_ready = 1'b1; en = 3'b111;
        drv_a = '0; drv_b = '0; drv_op = '0; drv_tag = '0; drv_exp = '0; done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("reset_valid_p%0d", d + 1), 64'(ov[d]), 64'(0));
            chk($sformatf("reset_data_p%0d", d + 1), 64'(od[d]), 64'(0));
            chk($sformatf("reset_tag_p%0d", d + 1), 64'(ot[d]), 64'(0));
            chk($sformatf("reset_ready_p%0d", d + 1), 64'(ir[d]), 64'(1));
        end

        // Directed vectors with hand-computed results
        lat_check(32'h8000_0000, 5'd31, 2'b11, 5'd1,  32'hFFFF_FFFF);
        lat_check(32'h0000_0001, 5'd31, 2'b00, 5'd2,  32'h8000_0000);
        lat_check(32'hDEAD_BEEF, 5'd0,  2'b01, 5'd3,  32'hDEAD_BEEF);
        lat_check(32'h1234_5678, 5'd8,  2'b10, 5'd4,  32'h7812_3456);
        lat_check(32'h7000_0000, 5'd4,  2'b11, 5'd5,  32'h0700_0000);
        lat_check(32'h8000_0001, 5'd1,  2'b10, 5'd6,  32'hC000_0000);
        lat_check(32'hF000_000F, 5'd4,  2'b00, 5'd7,  32'h0000_00F0);
        lat_check(32'h8000_0000, 5'd31, 2'b01, 5'd8,  32'h0000_0001);
        lat_check(32'h8000_0000, 5'd0,  2'b11, 5'd9,  32'h8000_0000);
        lat_check(32'h0000_0001, 5'd31, 2'b10, 5'd10, 32'h0000_0002);
        lat_check(32'hF000_0000, 5'd4,  2'b11, 5'd11, 32'hFF00_0000);
        lat_check(32'hA5A5_A5A5, 5'd16, 2'b10, 5'd12, 32'hA5A5_A5A5);

        // Backpressure on the 3-stage instance: six tagged ops, sink stalled 5 cycles
        idle(3);
        p0 = pops[2];
        fork
            begin
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                for (int k = 1; k <= 6; k++) begin
                    send(2, 32'h8000_0000, 5'(k), 2'b01, 5'(k), 32'h8000_0000 >> k);
                    if (k == 3) begin
                        @(negedge clk);
                        chk("bp_in_ready_full", 64'(ir[2]), 64'(0));
                    end
                end
            end
        join
        wait_drain(2);
        chk("bp_exit_count", 64'(pops[2] - p0), 64'(6));

        // Flush with ops in flight and a new op offered in the same cycle
        idle(3);
        out_ready = 1'b0; en = 3'b111;
        drv_a = 32'h1; drv_b = 5'd1; drv_op = 2'b00; drv_tag = 5'd20; drv_exp = 32'h2;
        drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_a = 32'h4; drv_tag = 5'd21; drv_exp = 32'h8;
        @(posedge clk); #1;
        drv_a = 32'h10; drv_tag = 5'd22; drv_exp = 32'h20; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; drv_valid = 1'b0;
        for (int d = 0; d < ND; d++)
            chk($sformatf("flush_valid_p%0d", d + 1), 64'(ov[d]), 64'(0));
        out_ready = 1'b1;
        idle(5);
        lat_check(32'h0000_00F0, 5'd4, 2'b01, 5'd23, 32'h0000_000F);

        // Reset pulse in the middle of a stream
        en = 3'b111;
        for (int k = 0; k < 3; k++) begin
            drv_a = 32'hC000_0000 | 32'(k); drv_b = 5'(k + 1); drv_op = 2'b11;
            drv_tag = 5'(24 + k); drv_exp = ref_shift(drv_a, drv_b, drv_op);
            drv_valid = 1'b1;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; drv_valid = 1'b0;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("midrst_valid_p%0d", d + 1), 64'(ov[d]), 64'(0));
            chk($sformatf("midrst_data_p%0d", d + 1), 64'(od[d]), 64'(0));
            chk($sformatf("midrst_tag_p%0d", d + 1), 64'(ot[d]), 64'(0));
            chk($sformatf("midrst_ready_p%0d", d + 1), 64'(ir[d]), 64'(1));
        end
        idle(5);

        // Random back-to-back ops with random sink stalls, per instance
        for (int d = 0; d < ND; d++) begin
            done = 1'b0;
            fork
                begin
                    while (!done) begin
                        @(posedge clk); #1;
                        out_ready = ($urandom_range(0, 3) != 0);
                    end
                end
                begin
                    for (int k = 0; k < 30; k++) begin
                        ra = $urandom;
                        rb = 5'($urandom_range(0, 31));
                        rop = 2'($urandom_range(0, 3));
                        send(d, ra, rb, rop, 5'($urandom_range(0, 31)), ref_shift(ra, rb, rop));
                    end
                    done = 1'b1;
                end
            join
            out_ready = 1'b1;
            wait_drain(d);
        end

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
